csr_access_unit: RTL and testbench
==================================

# csr_access_unit

Execute-stage CSR access unit sitting directly upstream of the counter CSR file. It accepts decoded Zicsr instructions over a valid/ready handshake, drives the counter file's address input, and merges its combinational read data with four locally held machine CSRs. It performs the read-modify-write and returns a registered rd writeback result plus a retire pulse to the downstream stage.

## Interface
- MTVEC_RST, 32'h0000_0000, reset value of mtvec (bits [1:0] ignored, forced 0)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction presented
- in_ready  out  1  unit can accept this cycle
- in_funct3  in  3  001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- in_csr_addr  in  12  CSR address
- in_rs1_data  in  32  rs1 operand (register forms)
- in_rs1_idx  in  5  rs1 index; zero-extended zimm for immediate forms
- in_rd_idx  in  5  destination register
- cnt_addr  out  32  to counter file immex; {20'b0, in_csr_addr}, combinational
- cnt_rdata  in  32  counter file read data, combinational
- out_valid  out  1  result held
- out_ready  in  1  downstream accepts
- out_rd_idx  out  5  writeback register
- out_rd_data  out  32  old CSR value
- out_rd_we  out  1  writeback enable
- out_illegal  out  1  instruction raised illegal-instruction
- retire  out  1  = out_valid & out_ready & ~out_illegal

## Operation
- Local CSRs: mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342. Counter addresses 0xC00, 0xC02, 0xC80, 0xC82 read via cnt_rdata; read-only.
- Accept = in_valid & in_ready; in_ready = ~out_valid | out_ready.
- On accept: old = local CSR value or cnt_rdata; src = in_rs1_data (funct3[2]=0) or {27'b0, in_rs1_idx}.
- New value: RW/RWI src; RS/RSI old|src; RC/RCI old&~src.
- Write intent: RW/RWI always; RS/RC/RSI/RCI only when in_rs1_idx != 0.
- Local CSR written at the accept edge; mtvec[1:0] and mepc[1:0] always stored as 00.
- out_rd_data = old; out_rd_idx = in_rd_idx; out_rd_we = (in_rd_idx != 0) & ~illegal.
- Illegal conditions: funct3 000 or 100; unknown address; write intent to counter address. Illegal ops perform no CSR write, out_rd_we=0.
- Single result register; no internal queue.

## Timing
- Reset: out_valid 0, out_rd_idx 0, out_rd_data 0, out_rd_we 0, out_illegal 0, retire 0, mscratch/mepc/mcause 0, mtvec MTVEC_RST & ~32'h3.
- Latency 1 cycle: accept at edge N, out_valid high after edge N.
- Result stable while out_valid & ~out_ready; in_ready low, no new accept.
- Back-to-back: same-cycle out_ready & in_valid accepts new op, result replaced at same edge, out_valid stays 1.
- Back-to-back write then read of same local CSR returns new value.
- Counter read sampled at the accept edge; stalled results not refreshed.
- Reset mid-operation clears pending result; no retire emitted.

## Configuration
- CSR_ILLEGAL_TRAP_EN defined: illegal conditions set out_illegal=1 with the result; retire suppressed.
- Undefined: out_illegal tied 0; illegal ops complete as no-ops with out_rd_we=0, unknown-address reads return 32'hFFFF_FFFF, counter writes ignored, retire asserted.

## Test plan
- Reset release, then CSRRW 0x340 rs1_data=0xDEADBEEF rd=5 -> out_rd_data 0, rd_we 1; following CSRRS 0x340 rs1_idx=0 rd=6 -> out_rd_data 0xDEADBEEF, mscratch unchanged.
- CSRRWI 0x305 zimm=0x1F -> mtvec reads 0x0000001C; CSRRCI 0x305 zimm=0x0C -> next read 0x00000010.
- cnt_rdata=0x12345678 with CSRRS 0xC00 rs1_idx=0 rd=1 -> out_rd_data 0x12345678, cnt_addr 0x00000C00, retire 1.
- CSRRW 0xC00 rs1=3 -> with macro out_illegal 1, rd_we 0, retire 0; without macro out_illegal 0, rd_we 0, retire 1.
- out_ready held 0 for 3 cycles after result -> in_ready 0, out_rd_data stable; out_ready 1 with new in_valid -> new result next cycle, one retire per op.
- rst_n asserted with out_valid 1 -> out_valid 0 immediately, mtvec returns to MTVEC_RST & ~3.

Source files
------------

// File: rtl/csr_access_unit_if.sv
// Bus bundle for csr_access_unit: issue handshake, counter-file port and
// writeback result. The slave side is the CSR unit; the master side is
// whoever plays issue stage, counter file and writeback stage together.
interface csr_access_unit_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic [11:0] in_csr_addr;
    logic [31:0] in_rs1_data;
    logic [4:0]  in_rs1_idx;
    logic [4:0]  in_rd_idx;
    logic [31:0] cnt_addr;
    logic [31:0] cnt_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd_idx;
    logic [31:0] out_rd_data;
    logic        out_rd_we;
    logic        out_illegal;
    logic        retire;

    modport slave (
        input  in_valid, in_funct3, in_csr_addr, in_rs1_data, in_rs1_idx,
               in_rd_idx, cnt_rdata, out_ready,
        output in_ready, cnt_addr, out_valid, out_rd_idx, out_rd_data,
               out_rd_we, out_illegal, retire
    );

    modport master (
        output in_valid, in_funct3, in_csr_addr, in_rs1_data, in_rs1_idx,
               in_rd_idx, cnt_rdata, out_ready,
        input  in_ready, cnt_addr, out_valid, out_rd_idx, out_rd_data,
               out_rd_we, out_illegal, retire
    );
endinterface

// File: rtl/csr_access_unit.sv
// csr_access_unit: execute-stage Zicsr read-modify-write unit. Holds mtvec,
// mscratch, mepc and mcause locally and reads the counter CSRs through the
// combinational counter-file port. One registered result slot.
// Optional feature macro: CSR_ILLEGAL_TRAP_EN -- when defined, illegal
// accesses are flagged on out_illegal and do not retire; when undefined they
// complete as no-op writebacks that still retire.
module csr_access_unit #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    csr_access_unit_if.slave bus
);
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET  = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH = 12'hC82;

`ifdef CSR_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;

    logic        out_valid_q;
    logic [4:0]  rd_idx_q;
    logic [31:0] rd_data_q;
    logic        rd_we_q;
    logic        illegal_q;

    logic        in_ready;
    logic        accept;
    logic        is_local;
    logic        is_counter;
    logic        write_intent;
    logic        illegal;
    logic        local_we;
    logic [31:0] local_old;
    logic [31:0] old_value;
    logic [31:0] src_value;
    logic [31:0] new_value;

    assign in_ready     = ~out_valid_q | bus.out_ready;
    assign accept       = bus.in_valid & in_ready;
    assign bus.in_ready = in_ready;
    assign bus.cnt_addr = {20'b0, bus.in_csr_addr};

    // Decode the presented instruction: source CSR, operand, new value, legality
    always_comb begin
        is_local  = 1'b1;
        local_old = 32'h0;
        case (bus.in_csr_addr)
            ADDR_MTVEC:    local_old = mtvec;
            ADDR_MSCRATCH: local_old = mscratch;
            ADDR_MEPC:     local_old = mepc;
            ADDR_MCAUSE:   local_old = mcause;
            default:       is_local  = 1'b0;
        endcase

        is_counter = (bus.in_csr_addr == ADDR_CYCLE)  | (bus.in_csr_addr == ADDR_INSTRET) |
                     (bus.in_csr_addr == ADDR_CYCLEH) | (bus.in_csr_addr == ADDR_INSTRETH);

        // Plain writes always write; set/clear forms only when rs1/zimm is nonzero
        write_intent = (bus.in_funct3[1:0] == 2'b01) | (bus.in_rs1_idx != 5'd0);

        illegal = (bus.in_funct3[1:0] == 2'b00) | ~(is_local | is_counter) |
                  (is_counter & write_intent);

        if (is_local) begin
            old_value = local_old;
        end else if (is_counter) begin
            old_value = bus.cnt_rdata;
        end else begin
            old_value = 32'hFFFF_FFFF;
        end

        src_value = bus.in_funct3[2] ? {27'b0, bus.in_rs1_idx} : bus.in_rs1_data;

        case (bus.in_funct3[1:0])
            2'b01:   new_value = src_value;
            2'b10:   new_value = old_value | src_value;
            2'b11:   new_value = old_value & ~src_value;
            default: new_value = old_value;
        endcase

        local_we = accept & is_local & write_intent & ~illegal;
    end

    // Local machine CSR storage, updated at the accept edge; mtvec/mepc stay word aligned
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtvec    <= {MTVEC_RST[31:2], 2'b00};
            mscratch <= 32'h0;
            mepc     <= 32'h0;
            mcause   <= 32'h0;
        end else if (local_we) begin
            case (bus.in_csr_addr)
                ADDR_MTVEC:    mtvec    <= {new_value[31:2], 2'b00};
                ADDR_MSCRATCH: mscratch <= new_value;
                ADDR_MEPC:     mepc     <= {new_value[31:2], 2'b00};
                ADDR_MCAUSE:   mcause   <= new_value;
                default:       mcause   <= mcause;
            endcase
        end
    end

    // Single result slot: load on accept, drain when downstream takes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            rd_idx_q    <= 5'd0;
            rd_data_q   <= 32'h0;
            rd_we_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            rd_idx_q    <= bus.in_rd_idx;
            rd_data_q   <= old_value;
            rd_we_q     <= (bus.in_rd_idx != 5'd0) & ~illegal;
            illegal_q   <= TRAP_EN & illegal;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_rd_idx  = rd_idx_q;
    assign bus.out_rd_data = rd_data_q;
    assign bus.out_rd_we   = rd_we_q;
    assign bus.out_illegal = illegal_q;
    assign bus.retire      = out_valid_q & bus.out_ready & ~illegal_q;
endmodule

// File: tb/tb_csr_access_unit.sv
// Testbench for csr_access_unit: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_csr_access_unit;
    localparam logic [31:0] TB_MTVEC = 32'h8000_0103;
`ifdef CSR_ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    csr_access_unit_if bus();

    csr_access_unit #(.MTVEC_RST(TB_MTVEC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [31:0] modelCsr [logic [11:0]];
    bit          mValid;
    logic [4:0]  mIdx;
    logic [31:0] mData;
    bit          mWe;
    bit          mIll;

    logic [11:0] addrPool [10] = '{12'h305, 12'h340, 12'h341, 12'h342, 12'hC00,
                                   12'hC02, 12'hC80, 12'hC82, 12'h300, 12'hC01};

    task automatic checkVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic modelReset();
        mValid = 1'b0;
        mIdx   = 5'd0;
        mData  = 32'h0;
        mWe    = 1'b0;
        mIll   = 1'b0;
        modelCsr.delete();
        modelCsr[12'h305] = TB_MTVEC & ~32'h3;
        modelCsr[12'h340] = 32'h0;
        modelCsr[12'h341] = 32'h0;
        modelCsr[12'h342] = 32'h0;
    endtask

    // Architectural effect of one clock edge given the currently driven inputs
    task automatic modelStep();
        bit          inReady;
        bit          isLocal;
        bit          isCnt;
        bit          wants;
        bit          bad;
        int          op;
        logic [11:0] a;
        logic [31:0] oldV;
        logic [31:0] srcV;
        logic [31:0] newV;
        inReady = !mValid || bus.out_ready;
        if (bus.in_valid && inReady) begin
            a       = bus.in_csr_addr;
            op      = int'(bus.in_funct3) % 4;
            isLocal = modelCsr.exists(a) != 0;
            isCnt   = (a == 12'hC00) || (a == 12'hC02) || (a == 12'hC80) || (a == 12'hC82);
            wants   = (op == 1) || (bus.in_rs1_idx != 0);
            bad     = (op == 0) || !(isLocal || isCnt) || (isCnt && wants);
            oldV    = isLocal ? modelCsr[a] : (isCnt ? bus.cnt_rdata : 32'hFFFF_FFFF);
            srcV    = (bus.in_funct3 >= 3'd4) ? 32'(bus.in_rs1_idx) : bus.in_rs1_data;
            newV    = (op == 1) ? srcV : (op == 2) ? (oldV | srcV) : (oldV & ~srcV);
            if (!bad && isLocal && wants) begin
                modelCsr[a] = ((a == 12'h305) || (a == 12'h341)) ? (newV & ~32'h3) : newV;
            end
            mValid = 1'b1;
            mIdx   = bus.in_rd_idx;
            mData  = oldV;
            mWe    = (bus.in_rd_idx != 0) && !bad;
            mIll   = TRAP_EN && bad;
        end else if (bus.out_ready) begin
            mValid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [2:0] f3, input logic [11:0] a,
                                 input logic [31:0] d, input logic [4:0] idx, input logic [4:0] rd,
                                 input logic [31:0] cnt, input logic ordy);
        bus.in_valid    = v;
        bus.in_funct3   = f3;
        bus.in_csr_addr = a;
        bus.in_rs1_data = d;
        bus.in_rs1_idx  = idx;
        bus.in_rd_idx   = rd;
        bus.cnt_rdata   = cnt;
        bus.out_ready   = ordy;
    endtask

    task automatic checkComb();
        checkVal("in_ready", 32'(bus.in_ready), 32'(!mValid || bus.out_ready));
        checkVal("cnt_addr", bus.cnt_addr, {20'b0, bus.in_csr_addr});
        checkVal("retire", 32'(bus.retire), 32'(mValid && bus.out_ready && !mIll));
    endtask

    task automatic checkOutput();
        checkVal("out_valid", 32'(bus.out_valid), 32'(mValid));
        if (mValid) begin
            checkVal("out_rd_idx", 32'(bus.out_rd_idx), 32'(mIdx));
            checkVal("out_rd_data", bus.out_rd_data, mData);
            checkVal("out_rd_we", 32'(bus.out_rd_we), 32'(mWe));
            checkVal("out_illegal", 32'(bus.out_illegal), 32'(mIll));
        end
    endtask

    // One cycle: combinational checks, edge, model update, registered checks
    task automatic runCycle();
        #1;
        checkComb();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    // Directed scenarios followed by randomized traffic
    initial begin
        modelReset();
        applyStimulus(1'b0, 3'd0, 12'h0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkVal("rst_out_valid", 32'(bus.out_valid), 32'h0);
        checkVal("rst_out_rd_idx", 32'(bus.out_rd_idx), 32'h0);
        checkVal("rst_out_rd_data", bus.out_rd_data, 32'h0);
        checkVal("rst_out_rd_we", 32'(bus.out_rd_we), 32'h0);
        checkVal("rst_out_illegal", 32'(bus.out_illegal), 32'h0);
        checkVal("rst_retire", 32'(bus.retire), 32'h0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 3'b001, 12'h340, 32'hDEAD_BEEF, 5'd7, 5'd5, 32'h0, 1'b1);
        runCycle();
        checkVal("lit_rw_mscratch_old", bus.out_rd_data, 32'h0);
        checkVal("lit_rw_mscratch_we", 32'(bus.out_rd_we), 32'h1);
        applyStimulus(1'b1, 3'b010, 12'h340, 32'h0, 5'd0, 5'd6, 32'h0, 1'b1);
        runCycle();
        checkVal("lit_rs_mscratch", bus.out_rd_data, 32'hDEAD_BEEF);
        checkVal("lit_rs_mscratch_rd", 32'(bus.out_rd_idx), 32'd6);

        applyStimulus(1'b1, 3'b101, 12'h305, 32'h0, 5'h1F, 5'd1, 32'h0, 1'b1);
        runCycle();
        checkVal("lit_mtvec_reset_val", bus.out_rd_data, 32'h8000_0100);
        applyStimulus(1'b1, 3'b010, 12'h305, 32'h0, 5'd0, 5'd1, 32'h0, 1'b1);
        runCycle();
        checkVal("lit_mtvec_rwi", bus.out_rd_data, 32'h0000_001C);
        applyStimulus(1'b1, 3'b111, 12'h305, 32'h0, 5'h0C, 5'd1, 32'h0, 1'b1);
        runCycle();
        applyStimulus(1'b1, 3'b010, 12'h305, 32'h0, 5'd0, 5'd1, 32'h0, 1'b1);
        runCycle();
        checkVal("lit_mtvec_rci", bus.out_rd_data, 32'h0000_0010);

        applyStimulus(1'b1, 3'b010, 12'hC00, 32'h0, 5'd0, 5'd1, 32'h1234_5678, 1'b1);
        #1;
        checkVal("lit_cnt_addr", bus.cnt_addr, 32'h0000_0C00);
        runCycle();
        checkVal("lit_cnt_read", bus.out_rd_data, 32'h1234_5678);
        applyStimulus(1'b1, 3'b001, 12'hC00, 32'h0000_0003, 5'd3, 5'd4, 32'h0BAD_0BAD, 1'b1);
        #1;
        checkVal("lit_cnt_retire", 32'(bus.retire), 32'h1);
        runCycle();
        checkVal("lit_cnt_write_illegal", 32'(bus.out_illegal), 32'(TRAP_EN));
        checkVal("lit_cnt_write_we", 32'(bus.out_rd_we), 32'h0);
        applyStimulus(1'b0, 3'd0, 12'h0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b1);
        #1;
        checkVal("lit_cnt_write_retire", 32'(bus.retire), 32'(!TRAP_EN));
        runCycle();

        applyStimulus(1'b1, 3'b010, 12'h340, 32'h0, 5'd0, 5'd9, 32'h0, 1'b1);
        runCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 3'b001, 12'h341, 32'h0000_1235, 5'd2, 5'd3, 32'h0, 1'b0);
            #1;
            checkVal("lit_stall_in_ready", 32'(bus.in_ready), 32'h0);
            runCycle();
            checkVal("lit_stall_data", bus.out_rd_data, 32'hDEAD_BEEF);
        end
        applyStimulus(1'b1, 3'b001, 12'h341, 32'h0000_1235, 5'd2, 5'd3, 32'h0, 1'b1);
        runCycle();
        applyStimulus(1'b1, 3'b010, 12'h341, 32'h0, 5'd0, 5'd2, 32'h0, 1'b1);
        runCycle();
        checkVal("lit_mepc_b2b", bus.out_rd_data, 32'h0000_1234);

        applyStimulus(1'b1, 3'b010, 12'h342, 32'h0, 5'd0, 5'd8, 32'h0, 1'b0);
        runCycle();
        applyStimulus(1'b0, 3'd0, 12'h0, 32'h0, 5'd0, 5'd0, 32'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkVal("lit_midrst_valid", 32'(bus.out_valid), 32'h0);
        checkVal("lit_midrst_retire", 32'(bus.retire), 32'h0);
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'b010, 12'h305, 32'h0, 5'd0, 5'd1, 32'h0, 1'b1);
        runCycle();
        checkVal("lit_mtvec_after_rst", bus.out_rd_data, 32'h8000_0100);

        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 9) < 7),
                          3'($urandom_range(0, 7)),
                          addrPool[$urandom_range(0, 9)],
                          $urandom(),
                          ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31)),
                          $urandom(),
                          1'($urandom_range(0, 9) < 6));
            runCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
